gpio_selftest_seq: RTL and testbench
====================================

# gpio_selftest_seq

Wishbone master that runs a self-test over the `gpio_wb` peripheral. On `start` it checks each pad in turn:

- enable the pad's output driver
- drive it high, wait, read back the pad input
- drive it low, wait, read back again

A pad that fails either check sets its bit in a failure mask. When all pads are done, the block returns every pad to input with output low, then pulses `done`. It sits between the selftest control logic (the start/result bits in the CSR block) and the `gpio_wb` bus port; nothing else drives that port during a run.

## Interface

Parameters:
- `N`, 12: number of GPIO pads under test. Equals `gpio_wb` N; range 1..32.
- `SETTLE`, 4: idle cycles between a drive write and its readback. Minimum 1.
- `TIMEOUT`, 255: maximum cycles `wb_cyc` may stay high waiting for `wb_ack`. Range 1..255; counter is 8 bits.

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  one-cycle pulse; begins a run when idle.
- `busy`  out  1  high from the cycle after an accepted `start` until the cycle `done` pulses.
- `done`  out  1  one-cycle pulse at end of run (normal or aborted).
- `pass`  out  1  valid from `done` until the next accepted `start`; 1 iff `fail_mask`==0 and `err`==0.
- `err`  out  1  bus timeout occurred during the last run.
- `fail_mask`  out  N  bit k=1 means pad k failed a readback in the last run.
- `cur_pin`  out  5  index of the pad currently under test; diagnostic only.
- `wb_addr`  out  2  register select: 0 = OE, 1 = OUT, 2 = IN.
- `wb_wdata`  out  32  write data; bits above N are 0.
- `wb_rdata`  in  32  read data; sampled only when `wb_ack`=1.
- `wb_we`  out  1  write enable.
- `wb_cyc`  out  1  cycle request.
- `wb_ack`  in  1  slave acknowledge.

## Operation

Reset state (all outputs registered): `wb_cyc`, `wb_we`, `wb_addr`, `wb_wdata`, `busy`, `done`, `pass`, `err`, `fail_mask` and `cur_pin` are all 0. The FSM is in IDLE.

Bus transaction rules (master side):
- Raise `wb_cyc`, with `wb_we`/`wb_addr`/`wb_wdata` valid in the same cycle.
- Hold all four stable until `wb_ack`=1 is sampled.
- Drop `wb_cyc` (and `wb_we`) in the next cycle.
- `wb_cyc` stays low for at least one cycle between transactions.
- Any `wb_ack` seen while `wb_cyc`=0 is ignored.

FSM states:
- IDLE: on `start`, clear `fail_mask`/`err`/`pass`, set `cur_pin`=0 and `busy`=1, go to SET_OE.
- SET_OE: write OE = 1<<`cur_pin`.
- SET_HI: write OUT = 1<<`cur_pin`.
- WAIT_HI: SETTLE cycles, bus idle.
- READ_HI: read IN; if bit `cur_pin` is 0, set `fail_mask[cur_pin]`.
- SET_LO: write OUT = 0.
- WAIT_LO: SETTLE cycles, bus idle.
- READ_LO: read IN; if bit `cur_pin` is 1, set `fail_mask[cur_pin]`.
- NEXT: if `cur_pin`==N-1 go to CLR_OE; otherwise increment `cur_pin` and go to SET_OE.
- CLR_OE: write OE = 0.
- CLR_O: write OUT = 0.
- FIN: pulse `done`, drop `busy`, set `pass`, go to IDLE.

Rules and boundary conditions:
- Only bit `cur_pin` of IN is compared; other bits are don't-care.
- `start` while `busy` is ignored, with no effect on the run in progress.
- Timeout: if `wb_cyc` has been high for TIMEOUT cycles without an ack:
  - drop `wb_cyc` the next cycle, set `err`=1 and go straight to FIN (no cleanup writes);
  - FIN then gives `pass`=0;
  - `fail_mask` keeps the bits already collected.
- `rst_n` low mid-run: everything returns to reset values immediately and `wb_cyc` drops asynchronously. The peripheral's registers are not cleaned up; its own reset covers that.
- N=1: a single pad pass, then cleanup.

## Timing

- Against a slave that acks one cycle after `wb_cyc` rises, each transaction takes exactly 3 cycles: cyc, ack, gap.
- A WAIT state lasts exactly SETTLE cycles after the gap cycle of the preceding write.
- `busy` duration is N·(15 + 2·SETTLE) + 6 + 1 (FIN) cycles. For N=12, SETTLE=4 that is 283.
- Results (`fail_mask`, `err`, `pass`) are stable in the `done` cycle and stay stable until the next accepted `start`.
- `start` accepted in cycle t: `busy`=1 and `wb_cyc`=1 (OE write) in cycle t+1.

## Test plan

- Loopback-good model (`gpio_wb` + pads where IN follows OUT when OE set), N=12, SETTLE=4: pulse `start` → `done` 283 cycles later; `pass`=1, `fail_mask`=0x000, `err`=0; final bus writes are OE=0 then OUT=0.
- Pad 5 stuck low → `fail_mask`=0x020, `pass`=0. Pad 3 stuck high plus pad 11 stuck low → `fail_mask`=0x808.
- Slave never acks, TIMEOUT=255 → `wb_cyc` high for exactly 255 cycles then low; `done` pulses; `err`=1, `pass`=0; no further bus cycles.
- `start` re-pulsed at cycle 50 of a run → ignored; run length and results identical to the first scenario.
- `rst_n` pulled low at cycle 100 → all outputs 0 within the low phase. After release, a fresh `start` completes with `pass`=1.
- Slave with ack delayed 3 cycles → `wb_addr`/`wb_wdata`/`wb_we` stable until ack; one gap cycle between transactions; `pass`=1.

Source files
------------

// File: rtl/gpio_selftest_seq.sv
`default_nettype none
// ============================================================================
// Module   : gpio_selftest_seq
// Brief    : Wishbone master that walks every GPIO pad through a drive-high /
//            drive-low loopback check, collects a failure mask, then returns
//            all pads to input with output low and pulses done.
// Revision : 1.0 - initial release
// ============================================================================
module gpio_selftest_seq #(
  parameter int N       = 12,
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          err,
  output logic [N-1:0]  fail_mask,
  output logic [4:0]    cur_pin,
  output logic [1:0]    wb_addr,
  output logic [31:0]   wb_wdata,
  input  logic [31:0]   wb_rdata,
  output logic          wb_we,
  output logic          wb_cyc,
  input  logic          wb_ack
);

  localparam logic [1:0] c_addr_oe  = 2'd0;
  localparam logic [1:0] c_addr_out = 2'd1;
  localparam logic [1:0] c_addr_in  = 2'd2;

  localparam int                  c_wait_w    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(SETTLE - 1);
  localparam logic [7:0]          c_tmo_last  = 8'(TIMEOUT - 1);
  localparam logic [4:0]          c_pin_last  = 5'(N - 1);

  // The pad-advance decision (NEXT) is taken in the gap cycle of READ_LO,
  // so moving to the next pad costs no extra cycle.
  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_SET_OE  = 4'd1,
    S_SET_HI  = 4'd2,
    S_WAIT_HI = 4'd3,
    S_READ_HI = 4'd4,
    S_SET_LO  = 4'd5,
    S_WAIT_LO = 4'd6,
    S_READ_LO = 4'd7,
    S_CLR_OE  = 4'd8,
    S_CLR_O   = 4'd9,
    S_FIN     = 4'd10
  } state_t;

  state_t               r_state, w_state;
  logic                 r_cyc, w_cyc;
  logic                 r_we, w_we;
  logic [1:0]           r_addr, w_addr;
  logic [31:0]          r_wdata, w_wdata;
  logic                 r_busy, w_busy;
  logic                 r_done, w_done;
  logic                 r_pass, w_pass;
  logic                 r_err, w_err;
  logic [N-1:0]         r_fail, w_fail;
  logic [4:0]           r_pin, w_pin;
  logic [7:0]           r_tmo, w_tmo;
  logic [c_wait_w-1:0]  r_wait, w_wait;

  logic [31:0]          w_pin_mask;
  logic [31:0]          w_next_mask;
  logic                 w_hit;

  assign w_pin_mask  = 32'd1 << r_pin;
  assign w_next_mask = 32'd1 << (r_pin + 5'd1);
  assign w_hit       = |(wb_rdata & w_pin_mask);

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    w_state = r_state;
    w_cyc   = r_cyc;
    w_we    = r_we;
    w_addr  = r_addr;
    w_wdata = r_wdata;
    w_busy  = r_busy;
    w_done  = 1'b0;
    w_pass  = r_pass;
    w_err   = r_err;
    w_fail  = r_fail;
    w_pin   = r_pin;
    w_tmo   = r_tmo;
    w_wait  = r_wait;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_fail  = '0;
          w_err   = 1'b0;
          w_pass  = 1'b0;
          w_pin   = 5'd0;
          w_busy  = 1'b1;
          w_state = S_SET_OE;
          w_cyc   = 1'b1;
          w_we    = 1'b1;
          w_addr  = c_addr_oe;
          w_wdata = 32'd1;
          w_tmo   = 8'd0;
        end
      end

      S_WAIT_HI, S_WAIT_LO: begin
        if (r_wait == c_wait_last) begin
          w_state = (r_state == S_WAIT_HI) ? S_READ_HI : S_READ_LO;
          w_cyc   = 1'b1;
          w_we    = 1'b0;
          w_addr  = c_addr_in;
          w_wdata = 32'd0;
          w_tmo   = 8'd0;
        end else begin
          w_wait = r_wait + 1'b1;
        end
      end

      S_FIN: begin
        w_busy  = 1'b0;
        w_state = S_IDLE;
      end

      // Bus states: cyc phase (wait for ack or timeout), then one gap cycle.
      default: begin
        if (r_cyc) begin
          if (wb_ack) begin
            w_cyc = 1'b0;
            w_we  = 1'b0;
            if ((r_state == S_READ_HI && !w_hit) || (r_state == S_READ_LO && w_hit)) begin
              w_fail = r_fail | w_pin_mask[N-1:0];
            end
          end else if (r_tmo == c_tmo_last) begin
            // Abort: no cleanup writes, straight to the end-of-run pulse.
            w_cyc   = 1'b0;
            w_we    = 1'b0;
            w_err   = 1'b1;
            w_done  = 1'b1;
            w_state = S_FIN;
          end else begin
            w_tmo = r_tmo + 8'd1;
          end
        end else begin
          w_tmo = 8'd0;
          case (r_state)
            S_SET_OE: begin
              w_state = S_SET_HI;
              w_cyc   = 1'b1;
              w_we    = 1'b1;
              w_addr  = c_addr_out;
              w_wdata = w_pin_mask;
            end
            S_SET_HI: begin
              w_state = S_WAIT_HI;
              w_wait  = '0;
            end
            S_READ_HI: begin
              w_state = S_SET_LO;
              w_cyc   = 1'b1;
              w_we    = 1'b1;
              w_addr  = c_addr_out;
              w_wdata = 32'd0;
            end
            S_SET_LO: begin
              w_state = S_WAIT_LO;
              w_wait  = '0;
            end
            S_READ_LO: begin
              w_cyc = 1'b1;
              w_we  = 1'b1;
              w_addr = c_addr_oe;
              if (r_pin == c_pin_last) begin
                w_state = S_CLR_OE;
                w_wdata = 32'd0;
              end else begin
                w_state = S_SET_OE;
                w_pin   = r_pin + 5'd1;
                w_wdata = w_next_mask;
              end
            end
            S_CLR_OE: begin
              w_state = S_CLR_O;
              w_cyc   = 1'b1;
              w_we    = 1'b1;
              w_addr  = c_addr_out;
              w_wdata = 32'd0;
            end
            S_CLR_O: begin
              w_state = S_FIN;
              w_done  = 1'b1;
            end
            default: begin
              w_state = S_IDLE;
            end
          endcase
        end
      end
    endcase

    // Results are latched as the run ends so they are valid in the done cycle.
    if (w_done) begin
      w_pass = (w_fail == '0) && !w_err;
    end
  end

  // State and output registers; reset drops the bus request immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cyc   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= 2'd0;
      r_wdata <= 32'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= 1'b0;
      r_fail  <= '0;
      r_pin   <= 5'd0;
      r_tmo   <= 8'd0;
      r_wait  <= '0;
    end else begin
      r_state <= w_state;
      r_cyc   <= w_cyc;
      r_we    <= w_we;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_pass  <= w_pass;
      r_err   <= w_err;
      r_fail  <= w_fail;
      r_pin   <= w_pin;
      r_tmo   <= w_tmo;
      r_wait  <= w_wait;
    end
  end

  assign wb_cyc    = r_cyc;
  assign wb_we     = r_we;
  assign wb_addr   = r_addr;
  assign wb_wdata  = r_wdata;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err       = r_err;
  assign fail_mask = r_fail;
  assign cur_pin   = r_pin;

endmodule
`default_nettype wire

// File: tb/tb_gpio_selftest_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_selftest_seq
// Brief    : Directed bench for gpio_selftest_seq with a loopback gpio_wb
//            slave model (stuck pads, ack delay, no-ack) and a bus monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_selftest_seq;

  localparam int N       = 12;
  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 255;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, pass, err;
  logic [N-1:0]  fail_mask;
  logic [4:0]    cur_pin;
  logic [1:0]    wb_addr;
  logic [31:0]   wb_wdata, wb_rdata;
  logic          wb_we, wb_cyc, wb_ack;

  int checks = 0;
  int failures = 0;

  // Slave configuration
  int            dly = 1;
  bit            no_ack = 1'b0;
  bit            stray_ack = 1'b0;
  logic [N-1:0]  stuck_lo = '0;
  logic [N-1:0]  stuck_hi = '0;

  gpio_selftest_seq #(.N(N), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .pass(pass), .err(err), .fail_mask(fail_mask), .cur_pin(cur_pin),
    .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_rdata(wb_rdata),
    .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_ack(wb_ack)
  );

  always #5 clk = ~clk;

  // gpio_wb + pads model: IN follows OUT where OE is set, else pulled low.
  logic [N-1:0]  s_oe, s_out, pad_in;
  logic          s_ack;
  int            s_cnt;
  logic [31:0]   s_rdata;

  assign pad_in   = ((s_oe & s_out) | stuck_hi) & ~stuck_lo;
  assign wb_ack   = s_ack | stray_ack;
  assign wb_rdata = s_rdata;

  // Slave: ack dly cycles after cyc rises; upper IN bits are random noise.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_oe <= '0; s_out <= '0; s_ack <= 1'b0; s_cnt <= 0; s_rdata <= 32'd0;
    end else begin
      s_ack <= 1'b0;
      if (wb_cyc && !s_ack && !no_ack) begin
        if (s_cnt == dly - 1) begin
          s_ack <= 1'b1;
          s_cnt <= 0;
          if (wb_we) begin
            if (wb_addr == 2'd0) s_oe <= wb_wdata[N-1:0];
            else if (wb_addr == 2'd1) s_out <= wb_wdata[N-1:0];
          end else begin
            s_rdata <= ($urandom() & 32'hFFFF_F000) | {{(32-N){1'b0}}, pad_in};
          end
        end else begin
          s_cnt <= s_cnt + 1;
        end
      end else if (!wb_cyc) begin
        s_cnt <= 0;
      end
    end
  end

  // Bus monitor: stability while waiting, mandatory gap, write log, cyc lengths.
  logic         m_clr = 1'b0;
  logic         prev_cyc = 1'b0, prev_ack = 1'b0;
  int           cur_len = 0, max_len = 0, rises = 0, viol = 0;
  logic [1:0]   cap_addr = 2'd0;
  logic         cap_we = 1'b0;
  logic [31:0]  cap_wd = 32'd0;
  logic [1:0]   w0_addr = 2'd0, w1_addr = 2'd0;
  logic [31:0]  w0_data = 32'd0, w1_data = 32'd0;

  always @(posedge clk) begin
    if (m_clr) begin
      prev_cyc <= 1'b0; prev_ack <= 1'b0; cur_len <= 0; max_len <= 0;
      rises <= 0; viol <= 0;
      w0_addr <= 2'd3; w0_data <= 32'hDEAD_BEEF; w1_addr <= 2'd3; w1_data <= 32'hDEAD_BEEF;
    end else begin
      prev_cyc <= wb_cyc;
      prev_ack <= wb_ack;
      if (wb_cyc && !prev_cyc) begin
        cap_addr <= wb_addr; cap_we <= wb_we; cap_wd <= wb_wdata;
        rises <= rises + 1;
        cur_len <= 1;
        if (max_len < 1) max_len <= 1;
      end else if (wb_cyc) begin
        cur_len <= cur_len + 1;
        if (cur_len + 1 > max_len) max_len <= cur_len + 1;
      end
      viol <= viol
        + ((wb_cyc && prev_cyc && (wb_addr !== cap_addr || wb_we !== cap_we || wb_wdata !== cap_wd)) ? 1 : 0)
        + ((wb_cyc && prev_cyc && prev_ack) ? 1 : 0);
      if (wb_cyc && wb_ack && wb_we) begin
        w1_addr <= w0_addr; w1_data <= w0_data;
        w0_addr <= wb_addr; w0_data <= wb_wdata;
      end
    end
  end

  // Pulse start, then follow the run until done (bounded). Samples #1 after edges.
  task automatic run(input int restart_at, output int lat, output int busy_cnt,
                     output logic [36:0] first);
    int k;
    @(posedge clk); #1; m_clr = 1'b1; start = 1'b1;
    @(posedge clk); #1; m_clr = 1'b0; start = 1'b0;
    k = 1;
    first = {busy, wb_cyc, wb_we, wb_addr, wb_wdata};
    busy_cnt = (busy === 1'b1) ? 1 : 0;
    while (done !== 1'b1 && k < 3000) begin
      @(posedge clk); #1;
      k++;
      start = (k == restart_at);
      if (busy === 1'b1) busy_cnt++;
    end
    start = 1'b0;
    lat = k;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({wb_cyc, wb_we, wb_addr, wb_wdata, busy, done, pass, err, fail_mask, cur_pin} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got cyc=%b we=%b addr=%h wdata=%h busy=%b done=%b pass=%b err=%b mask=%h pin=%0d required all 0",
               wb_cyc, wb_we, wb_addr, wb_wdata, busy, done, pass, err, fail_mask, cur_pin);
    end
    rst_n = 1'b1;
    @(posedge clk); #1; stray_ack = 1'b1;
    @(posedge clk); #1; stray_ack = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({wb_cyc, busy, done, err, pass} !== 5'b0) begin
      failures++;
      $display("FAIL idle_stray_ack: got cyc/busy/done/err/pass=%b required 00000", {wb_cyc, busy, done, err, pass});
    end
  endtask

  task automatic test_loopback_good();
    int lat, bc;
    logic [36:0] f;
    dly = 1; no_ack = 1'b0; stuck_lo = '0; stuck_hi = '0;
    run(0, lat, bc, f);
    checks++;
    if (f !== {1'b1, 1'b1, 1'b1, 2'd0, 32'd1}) begin
      failures++; $display("FAIL good_first_cycle: got %h required %h", f, {1'b1, 1'b1, 1'b1, 2'd0, 32'd1});
    end
    checks++;
    if (lat !== 283) begin failures++; $display("FAIL good_latency: got %0d required 283", lat); end
    checks++;
    if (bc !== 283) begin failures++; $display("FAIL good_busy_len: got %0d required 283", bc); end
    checks++;
    if ({pass, err, fail_mask} !== {1'b1, 1'b0, 12'h000}) begin
      failures++; $display("FAIL good_result: got pass=%b err=%b mask=%h required 1 0 000", pass, err, fail_mask);
    end
    checks++;
    if (rises !== 62) begin failures++; $display("FAIL good_txn_count: got %0d required 62", rises); end
    checks++;
    if (viol !== 0) begin failures++; $display("FAIL good_bus_rules: got %0d violations required 0", viol); end
    checks++;
    if ({w1_addr, w1_data, w0_addr, w0_data} !== {2'd0, 32'd0, 2'd1, 32'd0}) begin
      failures++; $display("FAIL good_cleanup: got %h:%h then %h:%h required OE=0 then OUT=0", w1_addr, w1_data, w0_addr, w0_data);
    end
    @(posedge clk); #1;
    checks++;
    if ({done, busy} !== 2'b00) begin failures++; $display("FAIL good_after_done: got done/busy=%b required 00", {done, busy}); end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if ({pass, err, fail_mask} !== {1'b1, 1'b0, 12'h000}) begin
      failures++; $display("FAIL good_result_hold: got pass=%b err=%b mask=%h required 1 0 000", pass, err, fail_mask);
    end
  endtask

  task automatic test_stuck();
    int lat, bc;
    logic [36:0] f;
    stuck_lo = 12'h020; stuck_hi = '0;
    run(0, lat, bc, f);
    checks++;
    if ({pass, err, fail_mask} !== {1'b0, 1'b0, 12'h020}) begin
      failures++; $display("FAIL stuck5_result: got pass=%b err=%b mask=%h required 0 0 020", pass, err, fail_mask);
    end
    checks++;
    if (lat !== 283) begin failures++; $display("FAIL stuck5_latency: got %0d required 283", lat); end
    stuck_lo = 12'h800; stuck_hi = 12'h008;
    run(0, lat, bc, f);
    checks++;
    if ({pass, err, fail_mask} !== {1'b0, 1'b0, 12'h808}) begin
      failures++; $display("FAIL stuck3_11_result: got pass=%b err=%b mask=%h required 0 0 808", pass, err, fail_mask);
    end
    stuck_lo = '0; stuck_hi = '0;
  endtask

  task automatic test_timeout();
    int lat, bc;
    logic [36:0] f;
    no_ack = 1'b1;
    run(0, lat, bc, f);
    checks++;
    if (max_len !== 255) begin failures++; $display("FAIL tmo_cyc_len: got %0d required 255", max_len); end
    checks++;
    if (lat !== 256) begin failures++; $display("FAIL tmo_done_latency: got %0d required 256", lat); end
    checks++;
    if ({pass, err, fail_mask} !== {1'b0, 1'b1, 12'h000}) begin
      failures++; $display("FAIL tmo_result: got pass=%b err=%b mask=%h required 0 1 000", pass, err, fail_mask);
    end
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (rises !== 1 || wb_cyc !== 1'b0) begin
      failures++; $display("FAIL tmo_no_more_bus: got rises=%0d cyc=%b required 1 0", rises, wb_cyc);
    end
    no_ack = 1'b0;
  endtask

  task automatic test_restart();
    int lat, bc;
    logic [36:0] f;
    run(50, lat, bc, f);
    checks++;
    if (lat !== 283 || bc !== 283) begin
      failures++; $display("FAIL restart_latency: got lat=%0d busy=%0d required 283 283", lat, bc);
    end
    checks++;
    if ({pass, err, fail_mask, rises} !== {1'b1, 1'b0, 12'h000, 32'd62}) begin
      failures++; $display("FAIL restart_result: got pass=%b err=%b mask=%h txns=%0d required 1 0 000 62", pass, err, fail_mask, rises);
    end
  endtask

  task automatic test_reset_midrun();
    int lat, bc;
    logic [36:0] f;
    @(posedge clk); #1; m_clr = 1'b1; start = 1'b1;
    @(posedge clk); #1; m_clr = 1'b0; start = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    checks++;
    if ({busy, cur_pin} !== {1'b1, 5'd4}) begin
      failures++; $display("FAIL midrun_progress: got busy=%b pin=%0d required 1 4", busy, cur_pin);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({wb_cyc, wb_we, wb_addr, wb_wdata, busy, done, pass, err, fail_mask, cur_pin} !== '0) begin
      failures++; $display("FAIL midrun_async_reset: got cyc=%b busy=%b pin=%0d wdata=%h required all 0", wb_cyc, busy, cur_pin, wb_wdata);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run(0, lat, bc, f);
    checks++;
    if ({lat, pass, err, fail_mask} !== {32'd283, 1'b1, 1'b0, 12'h000}) begin
      failures++; $display("FAIL after_reset_run: got lat=%0d pass=%b err=%b mask=%h required 283 1 0 000", lat, pass, err, fail_mask);
    end
  endtask

  task automatic test_ack_delay();
    int lat, bc;
    logic [36:0] f;
    dly = 3;
    run(0, lat, bc, f);
    checks++;
    if (viol !== 0) begin failures++; $display("FAIL dly_bus_rules: got %0d violations required 0", viol); end
    checks++;
    if (lat !== 407) begin failures++; $display("FAIL dly_latency: got %0d required 407", lat); end
    checks++;
    if ({pass, err, fail_mask, rises} !== {1'b1, 1'b0, 12'h000, 32'd62}) begin
      failures++; $display("FAIL dly_result: got pass=%b err=%b mask=%h txns=%0d required 1 0 000 62", pass, err, fail_mask, rises);
    end
    dly = 1;
  endtask

  initial begin
    test_reset();
    test_loopback_good();
    test_stuck();
    test_timeout();
    test_restart();
    test_reset_midrun();
    test_ack_delay();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
